// File: rtl/signed_acc_sat_stage.sv
`default_nettype none
// ============================================================================
// Module   : signed_acc_sat_stage
// Brief    : Streaming signed accumulator stage with a one-entry registered
//            output (valid/ready). Each result carries an overflow flag.
//            The stage also keeps a sticky overflow flag and a saturating
//            count of overflow events.
//            Optional macro SIGNED_ACC_SATURATE_EN: clamp the result on
//            overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module signed_acc_sat_stage #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_overflow,
  output logic             sticky_overflow,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [W-1:0]     C_POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     C_NEG_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_out_data;
  logic             r_out_valid;
  logic             r_out_ovf;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic [W-1:0]     w_base;
  logic [W-1:0]     w_raw;
  logic             w_ovf;
  logic [W-1:0]     w_res;

  // The output register can take a new result when empty or draining now.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // A clear in the accept cycle discards the old sum, so the operand adds to zero.
  assign w_base = clear ? '0 : r_acc;
  assign w_raw  = w_base + in_data;

  // Overflow: operands share a sign and the wrapped sum does not.
  assign w_ovf = (w_base[W-1] == in_data[W-1]) && (w_raw[W-1] != w_base[W-1]);

`ifdef SIGNED_ACC_SATURATE_EN
  // Clamp toward the sign of the operands when the sum overflows.
  always_comb begin
    w_res = w_raw;
    if (w_ovf) begin
      w_res = w_base[W-1] ? C_NEG_MIN : C_POS_MAX;
    end
  end
`else
  // Plain two's-complement wrap-around.
  always_comb begin
    w_res = w_raw;
  end
`endif

  // Accumulator: load the result on accept, otherwise zero on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_res;
    end else if (clear) begin
      r_acc <= '0;
    end
  end

  // Output register: a new result wins over draining; data holds after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_ovf   <= w_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Overflow bookkeeping. With clear+accept the add cannot overflow, so clear alone decides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (clear) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept && w_ovf) begin
      r_sticky <= 1'b1;
      if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign out_overflow    = r_out_ovf;
  assign sticky_overflow = r_sticky;
  assign ovf_count       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_signed_acc_sat_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_acc_sat_stage
// Brief    : Self-checking bench for signed_acc_sat_stage (W=4, CNT_W=2).
//            Works with or without SIGNED_ACC_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signed_acc_sat_stage;

  localparam int W     = 4;
  localparam int CNT_W = 2;
`ifdef SIGNED_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_overflow;
  logic             sticky_overflow;
  logic [CNT_W-1:0] ovf_count;

  int checks   = 0;
  int failures = 0;

  signed_acc_sat_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_overflow    (out_overflow),
    .sticky_overflow (sticky_overflow),
    .ovf_count       (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
  } res_t;

  res_t             sb[$];
  logic [W-1:0]     m_acc;
  logic             m_valid;
  logic             m_sticky;
  int               m_cnt;

  // Model of the stage, stepped on the same edge as the DUT.
  always @(posedge clk or negedge rst_n) begin
    logic         rdy, acc_ok, ovf;
    logic [W-1:0] base, raw, res;
    if (!rst_n) begin
      m_acc = '0; m_valid = 1'b0; m_sticky = 1'b0; m_cnt = 0;
      sb.delete();
    end else begin
      rdy    = !m_valid || out_ready;
      acc_ok = in_valid && rdy;
      if (m_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (acc_ok) begin
        base = clear ? '0 : m_acc;
        raw  = base + in_data;
        ovf  = (base[W-1] == in_data[W-1]) && (raw[W-1] != base[W-1]);
        res  = raw;
        if (SAT && ovf) res = base[W-1] ? 4'h8 : 4'h7;
        sb.push_back('{data: res, ovf: ovf});
        m_acc   = res;
        m_valid = 1'b1;
        if (clear) begin m_sticky = 1'b0; m_cnt = 0; end
        if (ovf) begin
          m_sticky = 1'b1;
          if (m_cnt != 3) m_cnt++;
        end
      end else begin
        if (out_ready) m_valid = 1'b0;
        if (clear) begin m_acc = '0; m_sticky = 1'b0; m_cnt = 0; end
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sb_in_ready", int'(in_ready), int'(!m_valid || out_ready));
      chk("sb_out_valid", int'(out_valid), int'(m_valid));
      chk("sb_sticky", int'(sticky_overflow), int'(m_sticky));
      chk("sb_count", int'(ovf_count), m_cnt);
      if (m_valid) begin
        if (sb.size() == 0) begin
          chk("sb_queue_empty", 0, 1);
        end else begin
          chk("sb_out_data", int'(out_data), int'(sb[0].data));
          chk("sb_out_ovf", int'(out_overflow), int'(sb[0].ovf));
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic         clr;
    logic [W-1:0] din;
    logic [W-1:0] wd;  // wrap build: data, overflow, count
    logic         wo;
    int           wc;
    logic [W-1:0] sd;  // saturate build: data, overflow, count
    logic         so;
    int           sc;
  } vec_t;

  vec_t tv[16];

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] e_d;
    logic         e_o;
    int           e_c;
    int           exp_cnt[5];

    tv[0]  = '{1'b0, 4'h3, 4'h3, 1'b0, 0, 4'h3, 1'b0, 0};
    tv[1]  = '{1'b0, 4'h4, 4'h7, 1'b0, 0, 4'h7, 1'b0, 0};
    tv[2]  = '{1'b0, 4'h1, 4'h8, 1'b1, 1, 4'h7, 1'b1, 1};
    tv[3]  = '{1'b1, 4'h8, 4'h8, 1'b0, 0, 4'h8, 1'b0, 0};
    tv[4]  = '{1'b0, 4'hF, 4'h7, 1'b1, 1, 4'h8, 1'b1, 1};
    tv[5]  = '{1'b0, 4'h5, 4'hC, 1'b1, 2, 4'hD, 1'b0, 1};
    tv[6]  = '{1'b0, 4'h4, 4'h0, 1'b0, 2, 4'h1, 1'b0, 1};
    tv[7]  = '{1'b1, 4'h6, 4'h6, 1'b0, 0, 4'h6, 1'b0, 0};
    tv[8]  = '{1'b1, 4'h2, 4'h2, 1'b0, 0, 4'h2, 1'b0, 0};
    tv[9]  = '{1'b0, 4'hD, 4'hF, 1'b0, 0, 4'hF, 1'b0, 0};
    tv[10] = '{1'b0, 4'h9, 4'h8, 1'b0, 0, 4'h8, 1'b0, 0};
    tv[11] = '{1'b0, 4'h0, 4'h8, 1'b0, 0, 4'h8, 1'b0, 0};
    tv[12] = '{1'b0, 4'h8, 4'h0, 1'b1, 1, 4'h8, 1'b1, 1};
    tv[13] = '{1'b1, 4'h7, 4'h7, 1'b0, 0, 4'h7, 1'b0, 0};
    tv[14] = '{1'b0, 4'h0, 4'h7, 1'b0, 0, 4'h7, 1'b0, 0};
    tv[15] = '{1'b0, 4'h7, 4'hE, 1'b1, 1, 4'h7, 1'b1, 1};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ovf", int'(out_overflow), 0);
    chk("rst_sticky", int'(sticky_overflow), 0);
    chk("rst_count", int'(ovf_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: one operand per cycle with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      clear = tv[i].clr; in_valid = 1'b1; in_data = tv[i].din;
      @(posedge clk); #1;
      e_d = SAT ? tv[i].sd : tv[i].wd;
      e_o = SAT ? tv[i].so : tv[i].wo;
      e_c = SAT ? tv[i].sc : tv[i].wc;
      chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("vec%0d_data", i), int'(out_data), int'(e_d));
      chk($sformatf("vec%0d_ovf", i), int'(out_overflow), int'(e_o));
      chk($sformatf("vec%0d_count", i), int'(ovf_count), e_c);
      chk($sformatf("vec%0d_sticky", i), int'(sticky_overflow), int'(e_c != 0));
    end

    // Backpressure: result held, input blocked, then accepted on release.
    clear = 1'b1; in_valid = 1'b1; in_data = 4'h1;
    @(posedge clk); #1;
    clear = 1'b0; in_data = 4'h2; out_ready = 1'b0;
    held = out_data;
    chk("bp_first", int'(held), 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_low", int'(in_ready), 0);
      @(posedge clk); #1;
      chk("bp_data_stable", int'(out_data), int'(held));
      chk("bp_valid_held", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", int'(in_ready), 1);
    @(posedge clk); #1;
    chk("bp_next_data", int'(out_data), 3);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drained", int'(out_valid), 0);
    chk("bp_data_hold", int'(out_data), 3);

    // Counter saturation: five overflowing adds from acc=7.
    exp_cnt = '{1, 2, 3, 3, 3};
    clear = 1'b1; in_valid = 1'b1; in_data = 4'h7;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("cnt_start", int'(ovf_count), 0);
    for (int i = 0; i < 5; i++) begin
      in_data = (SAT || (i % 2 == 0)) ? 4'h7 : 4'h8;
      @(posedge clk); #1;
      chk($sformatf("cnt_step%0d_ovf", i), int'(out_overflow), 1);
      chk($sformatf("cnt_step%0d", i), int'(ovf_count), exp_cnt[i]);
    end

    // Asynchronous reset while a result is pending.
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_ovf", int'(out_overflow), 0);
    chk("arst_sticky", int'(sticky_overflow), 0);
    chk("arst_count", int'(ovf_count), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
